// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: instruction formats, base opcodes, decoded payload.
// No logic; imported by decode_fields and decode_stage.
// DECODE_ILLEGAL_CHECK_EN adds an illegal flag to the decoded payload.
package decode_stage_pkg;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE,
        INVALID_TYPE
    } inst_format_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Every RV immediate is a sign-extended 32-bit value, so 32 bits are kept per entry.
    typedef struct packed {
        inst_format_e fmt;
        logic [6:0]   opcode;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         rs1_used;
        logic         rs2_used;
        logic         rd_we;
        logic [31:0]  imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic         illegal;
`endif
    } decoded_inst_t;

    localparam decoded_inst_t DECODED_RESET = '{fmt: INVALID_TYPE, default: '0};

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I/RV64I field, format, immediate and register-use decode.
// Latency: 0 cycles (pure logic). No flow control.
// DECODE_ILLEGAL_CHECK_EN adds the illegal-encoding check.
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]   inst_i,
    output decoded_inst_t dec_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [4:0]   rd;
    inst_format_e fmt;
    logic [31:0]  imm;
    logic         src_fmt;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];
    assign rd  = inst_i[11:7];

    // Full 7-bit opcode match also rejects inst[1:0] != 2'b11.
    always_comb begin
        fmt = INVALID_TYPE;
        case (opc)
            OPC_OP:                                             fmt = R_TYPE;
            OPC_OP_32:                                          fmt = RV64 ? R_TYPE : INVALID_TYPE;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = I_TYPE;
            OPC_OP_IMM_32:                                      fmt = RV64 ? I_TYPE : INVALID_TYPE;
            OPC_STORE:                                          fmt = S_TYPE;
            OPC_BRANCH:                                         fmt = B_TYPE;
            OPC_LUI, OPC_AUIPC:                                 fmt = U_TYPE;
            OPC_JAL:                                            fmt = J_TYPE;
            default:                                            fmt = INVALID_TYPE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            I_TYPE:  imm = {{20{inst_i[31]}}, inst_i[31:20]};
            S_TYPE:  imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            B_TYPE:  imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            U_TYPE:  imm = {inst_i[31:12], 12'b0};
            J_TYPE:  imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign src_fmt = (fmt == R_TYPE) || (fmt == I_TYPE) || (fmt == S_TYPE) || (fmt == B_TYPE);

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic illegal;

    always_comb begin
        illegal = (fmt == INVALID_TYPE);
        if (fmt == R_TYPE) begin
            if (f7 != 7'b0000000 && f7 != 7'b0100000)
                illegal = 1'b1;
            if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
                illegal = 1'b1;
        end
        case (opc)
            OPC_LOAD:   if (f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110))) illegal = 1'b1;
            OPC_STORE:  if (f3[2] || (!RV64 && f3 == 3'b011)) illegal = 1'b1;
            OPC_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
            OPC_JALR:   if (f3 != 3'b000) illegal = 1'b1;
            default:    ;
        endcase
    end
`endif

    always_comb begin
        dec_o          = DECODED_RESET;
        dec_o.fmt      = fmt;
        dec_o.opcode   = opc;
        dec_o.funct3   = f3;
        dec_o.funct7   = f7;
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.rd       = rd;
        // CSR immediate forms (funct3[2]=1) carry a uimm in the rs1 slot.
        dec_o.rs1_used = src_fmt && (opc != OPC_FENCE) && !(opc == OPC_SYSTEM && f3[2]);
        dec_o.rs2_used = (fmt == R_TYPE) || (fmt == S_TYPE) || (fmt == B_TYPE);
        dec_o.rd_we    = ((fmt == R_TYPE) || (fmt == I_TYPE) || (fmt == U_TYPE) || (fmt == J_TYPE))
                         && (opc != OPC_FENCE) && (rd != 5'd0);
        dec_o.imm      = imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
        dec_o.illegal  = illegal;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main M, skid S); optional DECODE_ILLEGAL_CHECK_EN.
// Latency: 1 cycle from input accept to output when M is free; full throughput.
// Backpressure: in_ready_o = !S.valid (register-only); output payload frozen while stalled.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output inst_format_e     format_o,
    output logic [6:0]       opcode_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       funct7_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic             rs1_used_o,
    output logic             rs2_used_o,
    output logic             rd_we_o,
    output logic [XLEN-1:0]  imm_o,
`ifdef DECODE_ILLEGAL_CHECK_EN
    output logic             illegal_o,
`endif
    output logic [XLEN-1:0]  pc_o
);

    decoded_inst_t   dec;
    decoded_inst_t   m_q, m_d, s_q, s_d;
    logic [XLEN-1:0] pc_m_q, pc_m_d, pc_s_q, pc_s_d;
    logic            m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic            accept;

    decode_fields #(.XLEN(XLEN)) u_decode_fields (
        .inst_i (inst_i),
        .dec_o  (dec)
    );

    assign in_ready_o = !s_vld_q;
    assign accept     = in_valid_i && !s_vld_q;

    // S can only be valid while M is valid, so S never has to bypass to the output.
    always_comb begin
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        m_d     = m_q;
        s_d     = s_q;
        pc_m_d  = pc_m_q;
        pc_s_d  = pc_s_q;
        if (flush_i) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (s_vld_q) begin
            if (out_ready_i) begin
                m_d     = s_q;
                pc_m_d  = pc_s_q;
                s_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (m_vld_q && !out_ready_i) begin
                s_d     = dec;
                pc_s_d  = pc_i;
                s_vld_d = 1'b1;
            end else begin
                m_d     = dec;
                pc_m_d  = pc_i;
                m_vld_d = 1'b1;
            end
        end else if (out_ready_i) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            m_q     <= DECODED_RESET;
            s_q     <= DECODED_RESET;
            pc_m_q  <= RESET_PC;
            pc_s_q  <= RESET_PC;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            m_q     <= m_d;
            s_q     <= s_d;
            pc_m_q  <= pc_m_d;
            pc_s_q  <= pc_s_d;
        end
    end

    assign out_valid_o = m_vld_q;
    assign format_o    = m_q.fmt;
    assign opcode_o    = m_q.opcode;
    assign funct3_o    = m_q.funct3;
    assign funct7_o    = m_q.funct7;
    assign rs1_o       = m_q.rs1;
    assign rs2_o       = m_q.rs2;
    assign rd_o        = m_q.rd;
    assign rs1_used_o  = m_q.rs1_used;
    assign rs2_used_o  = m_q.rs2_used;
    assign rd_we_o     = m_q.rd_we;
    assign imm_o       = XLEN'($signed(m_q.imm));
    assign pc_o        = pc_m_q;
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal_o   = m_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: an XLEN=32 and an XLEN=64 instance share the same stimulus.
// Expected values are hand-computed from the instruction encodings.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;

    logic         in_ready, out_valid, rs1_used, rs2_used, rd_we;
    inst_format_e format;
    logic [6:0]   opcode, funct7;
    logic [2:0]   funct3;
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  imm, pc_o;

    logic         in_ready64, out_valid64, rs1_used64, rs2_used64, rd_we64;
    inst_format_e format64;
    logic [6:0]   opcode64, funct7_64;
    logic [2:0]   funct3_64;
    logic [4:0]   rs1_64, rs2_64, rd64;
    logic [63:0]  imm64, pc_o64;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic         illegal, illegal64;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage #(.XLEN(32), .RESET_PC(32'h0000_1000)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst), .pc_i(pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .format_o(format), .opcode_o(opcode), .funct3_o(funct3), .funct7_o(funct7),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .rs1_used_o(rs1_used), .rs2_used_o(rs2_used), .rd_we_o(rd_we),
        .imm_o(imm),
`ifdef DECODE_ILLEGAL_CHECK_EN
        .illegal_o(illegal),
`endif
        .pc_o(pc_o)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready64), .inst_i(inst), .pc_i({32'h0, pc}),
        .out_valid_o(out_valid64), .out_ready_i(out_ready),
        .format_o(format64), .opcode_o(opcode64), .funct3_o(funct3_64), .funct7_o(funct7_64),
        .rs1_o(rs1_64), .rs2_o(rs2_64), .rd_o(rd64),
        .rs1_used_o(rs1_used64), .rs2_used_o(rs2_used64), .rd_we_o(rd_we64),
        .imm_o(imm64),
`ifdef DECODE_ILLEGAL_CHECK_EN
        .illegal_o(illegal64),
`endif
        .pc_o(pc_o64)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        n_tests++;
        if ({out_valid, in_ready, format, pc_o, imm, rd, rd_we, rs1_used, rs2_used}
            !== {1'b0, 1'b1, INVALID_TYPE, 32'h1000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset32: got %h want %h",
                     {out_valid, in_ready, format, pc_o, imm, rd, rd_we, rs1_used, rs2_used},
                     {1'b0, 1'b1, INVALID_TYPE, 32'h1000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        end
        n_tests++;
        if ({out_valid64, in_ready64, format64, pc_o64, imm64} !== {1'b0, 1'b1, INVALID_TYPE, 64'h0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset64: got %h want %h", {out_valid64, in_ready64, format64, pc_o64, imm64},
                     {1'b0, 1'b1, INVALID_TYPE, 64'h0, 64'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        in_valid = 1'b1; inst = 32'hFFF0_8293; pc = 32'h100; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_accept: got %b want 10", {in_ready, out_valid});
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, format, opcode, funct3, rd, rs1, imm, rd_we, rs1_used, rs2_used, pc_o}
            !== {1'b1, I_TYPE, 7'h13, 3'd0, 5'd5, 5'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL single_addi: got %h want %h",
                     {out_valid, format, opcode, funct3, rd, rs1, imm, rd_we, rs1_used, rs2_used, pc_o},
                     {1'b1, I_TYPE, 7'h13, 3'd0, 5'd5, 5'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h100});
        end
        n_tests++;
        if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL single_imm64: got %h want ffffffffffffffff", imm64);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({out_valid, imm, rd} !== {1'b0, 32'hFFFF_FFFF, 5'd5}) begin
            n_fail++;
            $display("FAIL single_empty_hold: got %h want %h", {out_valid, imm, rd}, {1'b0, 32'hFFFF_FFFF, 5'd5});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  insts [4] = '{32'h1234_50B7, 32'h0020_A423, 32'hFE00_0EE3, 32'h0010_00EF};
        logic [31:0]  eimm  [4] = '{32'h1234_5000, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0800};
        inst_format_e efmt  [4] = '{U_TYPE, S_TYPE, B_TYPE, J_TYPE};
        logic [2:0]   eflg  [4] = '{3'b001, 3'b110, 3'b110, 3'b001};
        logic [31:0]  epc;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) begin
                in_valid = 1'b1; inst = insts[i]; pc = 32'h200 + 32'(4 * i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                epc = 32'h200 + 32'(4 * (i - 1));
                n_tests++;
                if ({out_valid, format, imm, rs1_used, rs2_used, rd_we, pc_o}
                    !== {1'b1, efmt[i-1], eimm[i-1], eflg[i-1], epc}) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d]: got %h want %h", i - 1,
                             {out_valid, format, imm, rs1_used, rs2_used, rd_we, pc_o},
                             {1'b1, efmt[i-1], eimm[i-1], eflg[i-1], epc});
                end
            end
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] stim  [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0};
        logic        ev    [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        erdy  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] eimm  [6] = '{32'h0, 32'h1, 32'h1, 32'h1, 32'h2, 32'h2};
        logic [31:0] epc   [6] = '{32'h0, 32'h300, 32'h300, 32'h300, 32'h304, 32'h304};
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 3) begin
                in_valid = 1'b1; inst = stim[c]; pc = 32'h300 + 32'(4 * c);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            n_tests++;
            if ({in_ready, out_valid} !== {erdy[c], ev[c]}) begin
                n_fail++;
                $display("FAIL stall_hs[%0d]: got %b want %b", c, {in_ready, out_valid}, {erdy[c], ev[c]});
            end
            if (c > 0) begin
                n_tests++;
                if ({imm, pc_o} !== {eimm[c], epc[c]}) begin
                    n_fail++;
                    $display("FAIL stall_payload[%0d]: got %h want %h", c, {imm, pc_o}, {eimm[c], epc[c]});
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            tick();
            in_valid = 1'b1; inst = 32'h0050_0293; pc = 32'h400;
            if (k == 0) begin
                tick();
                in_valid = 1'b1; inst = 32'h0060_0313; pc = 32'h404;
            end
            tick();
            in_valid = 1'b1; inst = 32'h0070_0393; pc = 32'h408; flush = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready} !== {1'b1, (k == 1)}) begin
                n_fail++;
                $display("FAIL flush_pre[%0d]: got %b want %b", k, {out_valid, in_ready}, {1'b1, (k == 1)});
            end
            tick();
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                n_tests++;
                if ({out_valid, in_ready, out_valid64} !== 3'b010) begin
                    n_fail++;
                    $display("FAIL flush_post[%0d.%0d]: got %b want 010", k, c, {out_valid, in_ready, out_valid64});
                end
                tick();
            end
        end
    endtask

    task automatic test_xlen();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; inst = 32'h0010_829B; pc = 32'h500;
        tick();
        in_valid = 1'b1; inst = 32'h0020_8033; pc = 32'h504;
        @(negedge clk);
        n_tests++;
        if ({format, rd_we, rs1_used, rs2_used, imm} !== {INVALID_TYPE, 3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL addiw_x32: got %h want %h", {format, rd_we, rs1_used, rs2_used, imm},
                     {INVALID_TYPE, 3'b000, 32'h0});
        end
        n_tests++;
        if ({format64, rd_we64, rs1_used64, rs2_used64, rd64, imm64} !== {I_TYPE, 3'b110, 5'd5, 64'h1}) begin
            n_fail++;
            $display("FAIL addiw_x64: got %h want %h", {format64, rd_we64, rs1_used64, rs2_used64, rd64, imm64},
                     {I_TYPE, 3'b110, 5'd5, 64'h1});
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({format, rd, rd_we, rs1_used, rs2_used, imm} !== {R_TYPE, 5'd0, 3'b011, 32'h0}) begin
            n_fail++;
            $display("FAIL add_x0: got %h want %h", {format, rd, rd_we, rs1_used, rs2_used, imm},
                     {R_TYPE, 5'd0, 3'b011, 32'h0});
        end
        tick();
    endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
    task automatic test_illegal();
        logic [31:0] iv [4] = '{32'h0220_8033, 32'h0000_0000, 32'h0000_90E7, 32'h4020_81B3};
        logic        ie [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            in_valid = 1'b1; inst = iv[i]; pc = 32'h600 + 32'(4 * i);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({out_valid, illegal, illegal64} !== {1'b1, ie[i], ie[i]}) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got %b want %b", i, {out_valid, illegal, illegal64},
                         {1'b1, ie[i], ie[i]});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_xlen();
`ifdef DECODE_ILLEGAL_CHECK_EN
        test_illegal();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, flow-controlled RV32I/RV64I decode stage between the fetch buffer and issue/regfile-read.
- Accepts raw instructions plus PC on a valid/ready input. Emits fully decoded fields, an XLEN-wide sign-extended immediate and register-use flags on a valid/ready output.
- A 2-entry skid buffer gives 1-cycle latency and full throughput, and keeps in_ready_o driven only from registers.

Parameters:
- XLEN, 32, datapath width (32 or 64); sets imm_o/pc width and enables the RV64 *W opcodes.
- RESET_PC, 0, reset value of pc_o.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drops all buffered entries.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept.
- inst_i  in  32  raw instruction.
- pc_i  in  XLEN  instruction PC.
- out_valid_o  out  1  decoded entry valid.
- out_ready_i  in  1  downstream accepts.
- format_o  out  inst_format_e  R/I/S/B/U/J/INVALID_TYPE.
- opcode_o  out  7  opcode field.
- funct3_o  out  3  funct3 field.
- funct7_o  out  7  funct7 field.
- rs1_o, rs2_o, rd_o  out  5 each  register fields.
- rs1_used_o, rs2_used_o  out  1 each  source register read required.
- rd_we_o  out  1  writes rd (forced 0 when rd==0).
- imm_o  out  XLEN  sign-extended immediate (0 for R/INVALID).
- pc_o  out  XLEN  registered PC.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - out_valid_o=0, both entries invalid, in_ready_o=1.
  - All payload outputs 0, format_o=INVALID_TYPE, pc_o=RESET_PC.
- Handshake:
  - Transfer occurs when valid&&ready in the same cycle.
  - out_valid_o must not drop and payload must not change while out_valid_o && !out_ready_i.
  - in_valid_i may be asserted independently of in_ready_o.
- Latency: an instruction accepted in cycle N is presented on the outputs in cycle N+1 if the main register is free.
- Buffer (main reg M, skid reg S):
  - in_ready_o = !S.valid (registered).
  - Accept while M is stalled: the entry goes to S.
  - M drains: S moves to M.
  - Simultaneous accept and drain with S empty: the new entry replaces M in the same edge; no bubble.
  - Sustained in_valid_i=out_ready_i=1 gives 1 instruction/cycle.
- Full (S valid): in_ready_o=0; input is ignored.
- Empty: out_valid_o=0, payload holds its last value.
- flush_i: next edge clears M.valid and S.valid; an input accepted in the flush cycle is discarded. Flush has priority over every other event.
- Decode is combinational on the input and registered with the entry; decode is never repeated at the output.
- Opcode to format mapping:
  - OP, OP-32 → R.
  - OP-IMM, OP-IMM-32, LOAD, JALR, FENCE, SYSTEM → I.
  - STORE → S. BRANCH → B. LUI, AUIPC → U. JAL → J.
  - OP-32 and OP-IMM-32 are decoded only when XLEN==64; otherwise INVALID.
- Immediates: all sign-extended from the top instruction bit to XLEN. U: inst[31:12]<<12, then sign-extended to XLEN.
- Register-use flags:
  - rs1_used: R/I/S/B, except LUI/AUIPC/JAL/FENCE and SYSTEM with funct3[2]=1.
  - rs2_used: R/S/B.
  - rd_we: R/I/U/J excluding FENCE, and only when rd!=0.
- INVALID_TYPE also applies when inst[1:0]!=2'b11. All use/we flags are 0 for INVALID_TYPE.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- With the macro: port illegal_o (out, 1, registered with the entry, reset 0). It is 1 when any of these holds:
  - format INVALID;
  - R-type funct7 is not 0000000/0100000;
  - R-type funct7=0100000 with funct3 not 000/101;
  - LOAD funct3 in {011 (XLEN32 only), 110 (XLEN32 only), 111};
  - STORE funct3[2]=1 or (XLEN32 and funct3=011);
  - BRANCH funct3 in {010, 011};
  - JALR funct3!=000.
- Without the macro: the port is absent and no check logic exists.

Decomposition:
- Package types: extend with opcode constants OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE, OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_FENCE, OPC_SYSTEM.
- Package types: add a packed struct decoded_inst_t holding all output payload fields. inst_format_e is unchanged.
- Sub-module decode_fields: purely combinational, inst_i → decoded_inst_t, parametrised by XLEN. decode_stage instantiates it and holds the M/S skid buffer.

Test Plan:
- Reset then single ADDI x5,x1,-1 (0xFFF08293), out_ready_i=1 → cycle+1: out_valid_o=1, format I, rd=5, rs1=1, imm_o=all ones, rd_we_o=1, rs2_used_o=0.
- Stream LUI/SW/BEQ/JAL back-to-back, out_ready_i=1 → one output/cycle, in_ready_o stays 1. Check imm values: LUI 0x12345000, BEQ offset -4, JAL +2048.
- Stall: out_ready_i=0 for 3 cycles with in_valid_i=1 → M holds a stable payload, S fills, in_ready_o=0 from cycle 2. Release → both entries drain in order, no loss or duplication.
- flush_i pulsed while M and S are valid and input accepted → next cycle out_valid_o=0, in_ready_o=1, flushed entries never appear.
- XLEN=32: ADDIW (opcode 0011011) → INVALID, flags 0. XLEN=64: same instruction → I-type, rd_we_o=1. ADD x0,x1,x2 → rd_we_o=0.
- DECODE_ILLEGAL_CHECK_EN: funct7=0000001 R-type, inst[1:0]=00, JALR funct3=001 → illegal_o=1 each. Legal SUB → illegal_o=0.
